// File: rtl/ekf_nl_pkg.sv
// Shared types, Q8.8 constants and CORDIC angle table for the
// EKF nonlinear co-processor.
package ekf_nl_pkg;

   localparam int RSA_DW = 16;
   localparam int FRAC   = 8;
   localparam int N_ITER = 14;
   localparam int GUARD  = 4;
   localparam int AW     = RSA_DW + 2;
   localparam int CW     = AW + GUARD;

   typedef logic signed [RSA_DW-1:0] q_t;
   typedef logic signed [AW-1:0]     w_t;
   typedef logic signed [CW-1:0]     c_t;

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_ITER, S_POST, S_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_PRD, OP_NEW, OP_UPD
   } op_e;

   localparam q_t PI      = 16'sh0324;
   localparam q_t HALF_PI = 16'sh0192;
   localparam q_t TWO_PI  = 16'sh0648;
   localparam q_t KINV    = 16'sh009B;

   // 1/K with 12 fractional bits; 0x9B alone is ~0.3% low.
   localparam logic signed [12:0] KINV_FINE = 13'sd2487;

   localparam q_t ATAN_LUT [0:N_ITER-1] = '{
      16'sd201, 16'sd119, 16'sd63, 16'sd32,
      16'sd16,  16'sd8,   16'sd4,  16'sd2,
      16'sd1,   16'sd0,   16'sd0,  16'sd0,
      16'sd0,   16'sd0
   };

   function automatic q_t sat(input w_t v);
      if (v > w_t'(32767))
         return q_t'(16'h7FFF);
      if (v < -w_t'(32768))
         return q_t'(16'h8000);
      return q_t'(v[RSA_DW-1:0]);
   endfunction

   function automatic w_t wrap(input w_t a);
      if (a >= w_t'(PI))
         return a - w_t'(TWO_PI);
      if (a < -w_t'(PI))
         return a + w_t'(TWO_PI);
      return a;
   endfunction

endpackage

// File: rtl/ekf_nonlinear_unit_if.sv
// Operand/result bundle between the RSA and the
// nonlinear co-processor.
interface ekf_nonlinear_unit_if;
   import ekf_nl_pkg::*;

   logic init_predict;
   logic init_newlm;
   logic init_update;
   q_t   xk, yk, xita;
   q_t   lkx, lky;
   q_t   vdt, wdt;
   q_t   r_meas, phi_meas;
   logic busy;
   logic done_predict;
   logic done_newlm;
   logic done_update;
   q_t   result_0, result_1, result_2;
   q_t   result_3, result_4, result_5;

   modport master (
      output init_predict, init_newlm, init_update,
      output xk, yk, xita, lkx, lky,
      output vdt, wdt, r_meas, phi_meas,
      input  busy, done_predict, done_newlm,
      input  done_update,
      input  result_0, result_1, result_2,
      input  result_3, result_4, result_5
   );

   modport slave (
      input  init_predict, init_newlm, init_update,
      input  xk, yk, xita, lkx, lky,
      input  vdt, wdt, r_meas, phi_meas,
      output busy, done_predict, done_newlm,
      output done_update,
      output result_0, result_1, result_2,
      output result_3, result_4, result_5
   );

endinterface

// File: rtl/cordic_iter.sv
// One combinational CORDIC micro-rotation, rotation or
// vectoring mode, at iteration index i_i.
module cordic_iter
   import ekf_nl_pkg::*;
(
   input  c_t         x_i,
   input  c_t         y_i,
   input  w_t         z_i,
   input  logic [3:0] i_i,
   input  logic       vec_i,
   output c_t         x_o,
   output c_t         y_o,
   output w_t         z_o
);

   c_t   xs, ys;
   w_t   a;
   logic up;

   always_comb begin
      xs = x_i >>> i_i;
      ys = y_i >>> i_i;
      a  = '0;
      if (int'(i_i) < N_ITER)
         a = w_t'(ATAN_LUT[i_i]);
      // counter-clockwise step when driving z or y toward zero
      up = vec_i ? y_i[CW-1] : ~z_i[AW-1];
      if (up) begin
         x_o = x_i - ys;
         y_o = y_i + xs;
         z_o = z_i - a;
      end else begin
         x_o = x_i + ys;
         y_o = y_i - xs;
         z_o = z_i + a;
      end
   end

endmodule

// File: rtl/ekf_nonlinear_unit.sv
// Trig/sqrt/atan2 co-processor for the RSA built around a
// single iterative CORDIC stage.
module ekf_nonlinear_unit
   import ekf_nl_pkg::*;
(
   input logic                 clk,
   input logic                 sys_rst,
   ekf_nonlinear_unit_if.slave bus
);

   state_e state_q;
   op_e    op_q, op_d;
   logic   busy_q, neg_q, pisg_q;
   logic   neg_d, pisg_d, start;
   logic [2:0] done_q;
   logic [3:0] cnt_q;
   q_t xk_q, yk_q, xita_q, wdt_q;
   q_t a_q, a_d;
   w_t b_q, b_d, z_q, z_d, z_n, ang;
   c_t x_q, y_q, x_d, y_d, x_n, y_n;
   logic signed [31:0]   pm;
   logic signed [33:0]   sq;
   logic signed [CW+13:0] mp;
   w_t cw, sw, pi_adj;
   q_t c16, s16, q16;
   logic [5:0][RSA_DW-1:0] res_q, res_d;

   assign start = bus.init_predict | bus.init_newlm
                | bus.init_update;

   cordic_iter u_cordic (
      .x_i   (x_q),
      .y_i   (y_q),
      .z_i   (z_q),
      .i_i   (cnt_q),
      .vec_i (op_q == OP_UPD),
      .x_o   (x_n),
      .y_o   (y_n),
      .z_o   (z_n)
   );

   always_comb begin
      op_d = OP_UPD;
      a_d  = sat(w_t'(bus.lkx) - w_t'(bus.xk));
      b_d  = w_t'(sat(w_t'(bus.lky) - w_t'(bus.yk)));
      if (bus.init_predict) begin
         op_d = OP_PRD;
         a_d  = bus.vdt;
         b_d  = w_t'(bus.xita);
      end else if (bus.init_newlm) begin
         op_d = OP_NEW;
         a_d  = bus.r_meas;
         b_d  = w_t'(bus.xita) + w_t'(bus.phi_meas);
      end
   end

   // Fold the angle into [-pi/2, pi/2]; neg restores the half-plane.
   always_comb begin
      ang    = wrap(b_q);
      pm     = a_q * KINV;
      neg_d  = 1'b0;
      pisg_d = 1'b0;
      x_d    = '0;
      y_d    = '0;
      z_d    = '0;
      if (op_q == OP_UPD) begin
         x_d = c_t'(a_q) <<< GUARD;
         y_d = c_t'(b_q) <<< GUARD;
         if (a_q[RSA_DW-1]) begin
            x_d    = -x_d;
            y_d    = -y_d;
            neg_d  = 1'b1;
            pisg_d = ~b_q[AW-1];
         end
      end else begin
         x_d = c_t'(pm >>> FRAC) <<< GUARD;
         z_d = ang;
         if (ang > w_t'(HALF_PI)) begin
            z_d   = ang - w_t'(PI);
            neg_d = 1'b1;
         end else if (ang < -w_t'(HALF_PI)) begin
            z_d   = ang + w_t'(PI);
            neg_d = 1'b1;
         end
      end
   end

   always_comb begin
      cw = w_t'(x_q >>> GUARD);
      sw = w_t'(y_q >>> GUARD);
      if (neg_q) begin
         cw = -cw;
         sw = -sw;
      end
      c16    = sat(cw);
      s16    = sat(sw);
      mp     = x_q * KINV_FINE;
      sq     = a_q * a_q + b_q * b_q;
      q16    = (sq > 34'sd8388607) ? q_t'(16'h7FFF)
                                   : q_t'(sq[23:8]);
      pi_adj = '0;
      if (neg_q)
         pi_adj = pisg_q ? w_t'(PI) : -w_t'(PI);
      res_d = '0;
      unique case (op_q)
         OP_PRD: begin
            res_d[0] = sat(w_t'(xk_q) + w_t'(c16));
            res_d[1] = sat(w_t'(yk_q) + w_t'(s16));
            res_d[2] = sat(wrap(w_t'(xita_q)
                                + w_t'(wdt_q)));
            res_d[3] = sat(-w_t'(s16));
            res_d[4] = c16;
         end
         OP_NEW: begin
            res_d[0] = sat(w_t'(xk_q) + w_t'(c16));
            res_d[1] = sat(w_t'(yk_q) + w_t'(s16));
            res_d[2] = sat(-w_t'(s16));
            res_d[3] = c16;
         end
         OP_UPD: begin
            res_d[0] = a_q;
            res_d[1] = b_q[RSA_DW-1:0];
            res_d[2] = sat(w_t'(mp >>> (12 + GUARD)));
            res_d[3] = sat(wrap(z_q + pi_adj
                                - w_t'(xita_q)));
            res_d[4] = q16;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_PRD;
         busy_q  <= 1'b0;
         done_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         pisg_q  <= 1'b0;
         xk_q    <= '0;
         yk_q    <= '0;
         xita_q  <= '0;
         wdt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         res_q   <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            S_IDLE: if (start) begin
               op_q    <= op_d;
               xk_q    <= bus.xk;
               yk_q    <= bus.yk;
               xita_q  <= bus.xita;
               wdt_q   <= bus.wdt;
               a_q     <= a_d;
               b_q     <= b_d;
               busy_q  <= 1'b1;
               state_q <= S_PREP;
            end
            S_PREP: begin
               x_q     <= x_d;
               y_q     <= y_d;
               z_q     <= z_d;
               neg_q   <= neg_d;
               pisg_q  <= pisg_d;
               cnt_q   <= '0;
               state_q <= S_ITER;
            end
            S_ITER: begin
               x_q   <= x_n;
               y_q   <= y_n;
               z_q   <= z_n;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(N_ITER - 1))
                  state_q <= S_POST;
            end
            S_POST: begin
               res_q   <= res_d;
               done_q  <= {op_q == OP_UPD,
                           op_q == OP_NEW,
                           op_q == OP_PRD};
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done_predict = done_q[0];
   assign bus.done_newlm   = done_q[1];
   assign bus.done_update  = done_q[2];
   assign bus.result_0     = res_q[0];
   assign bus.result_1     = res_q[1];
   assign bus.result_2     = res_q[2];
   assign bus.result_3     = res_q[3];
   assign bus.result_4     = res_q[4];
   assign bus.result_5     = res_q[5];

endmodule

// File: tb/tb_ekf_nonlinear_unit.sv
// Directed-vector bench for ekf_nonlinear_unit.
module tb_ekf_nonlinear_unit;

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ekf_nonlinear_unit_if bus ();

   ekf_nonlinear_unit dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input int got,
                      input int exp, input int tol = 0);
      int d;
      n_chk++;
      d = got - exp;
      if (d < 0)
         d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                  tag, got, exp, tol);
      end
   endtask

   function automatic int res(input int i);
      case (i)
         0: return int'(bus.result_0);
         1: return int'(bus.result_1);
         2: return int'(bus.result_2);
         3: return int'(bus.result_3);
         4: return int'(bus.result_4);
         default: return int'(bus.result_5);
      endcase
   endfunction

   function automatic logic [2:0] dones();
      return {bus.done_update, bus.done_newlm,
              bus.done_predict};
   endfunction

   task automatic set_pose(input int x, input int y,
                           input int th);
      bus.xk   = 16'(x);
      bus.yk   = 16'(y);
      bus.xita = 16'(th);
   endtask

   // Called #1 after an edge; init pulse lives in cycle t,
   // observation c is taken during cycle t+c.
   task automatic run_op(input logic p, input logic n,
                         input logic u, input bit late_new,
                         output int lat, output logic [2:0] dn,
                         output int pulses, output int blow);
      lat = 0;
      dn = '0;
      pulses = 0;
      blow = 0;
      bus.init_predict = p;
      bus.init_newlm   = n;
      bus.init_update  = u;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk);
         #1;
         bus.init_predict = 1'b0;
         bus.init_update  = 1'b0;
         bus.init_newlm   = late_new && (c == 3);
         if (c <= 17 && !bus.busy)
            blow++;
         if (dones() != 3'b000) begin
            pulses++;
            dn |= dones();
            if (lat == 0)
               lat = c;
         end
      end
   endtask

   initial begin
      int lat, pulses, blow;
      logic [2:0] dn;
      bus.init_predict = 1'b0;
      bus.init_newlm   = 1'b0;
      bus.init_update  = 1'b0;
      set_pose(0, 0, 0);
      bus.lkx = '0;
      bus.lky = '0;
      bus.vdt = '0;
      bus.wdt = '0;
      bus.r_meas = '0;
      bus.phi_meas = '0;

      // reset
      repeat (2) @(posedge clk);
      #1;
      sys_rst = 1'b0;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(dones()), 0);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rst_r%0d", i), res(i), 0);

      // predict, xita = 0
      set_pose(16'h0100, 16'h0200, 0);
      bus.vdt = 16'h0100;
      bus.wdt = 16'h0080;
      run_op(1, 0, 0, 0, lat, dn, pulses, blow);
      chk("prd_lat", lat, 17);
      chk("prd_which", int'(dn), 1);
      chk("prd_pulses", pulses, 1);
      chk("prd_busy_low", blow, 0);
      chk("prd_idle", int'(bus.busy), 0);
      chk("prd_r0", res(0), 512, 2);
      chk("prd_r1", res(1), 512, 2);
      chk("prd_r2", res(2), 128, 2);
      chk("prd_r3", res(3), 0, 2);
      chk("prd_r4", res(4), 256, 2);
      chk("prd_r5", res(5), 0);

      // predict with angle wrap, xita = 3.0
      set_pose(16'h0100, 16'h0200, 16'h0300);
      run_op(1, 0, 0, 0, lat, dn, pulses, blow);
      chk("wrap_lat", lat, 17);
      chk("wrap_r2", res(2), -713, 2);
      chk("wrap_r0", res(0), 3, 3);
      chk("wrap_r4", res(4), -253, 3);

      // update: dx=3, dy=4
      set_pose(0, 0, 0);
      bus.lkx = 16'h0300;
      bus.lky = 16'h0400;
      run_op(0, 0, 1, 0, lat, dn, pulses, blow);
      chk("upd_lat", lat, 17);
      chk("upd_which", int'(dn), 4);
      chk("upd_r0", res(0), 768);
      chk("upd_r1", res(1), 1024);
      chk("upd_r2", res(2), 1280, 2);
      chk("upd_r3", res(3), 237, 2);
      chk("upd_r4", res(4), 6400);
      chk("upd_r5", res(5), 0);

      // priority plus a newlm pulse while busy
      set_pose(16'h0100, 16'h0200, 0);
      run_op(1, 0, 1, 1, lat, dn, pulses, blow);
      chk("pri_lat", lat, 17);
      chk("pri_which", int'(dn), 1);
      chk("pri_pulses", pulses, 1);
      chk("pri_busy_low", blow, 0);
      chk("pri_r0", res(0), 512, 2);
      chk("pri_r4", res(4), 256, 2);

      // reset five cycles into an update
      pulses = 0;
      bus.init_update = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         bus.init_update = 1'b0;
         if (dones() != 3'b000)
            pulses++;
      end
      sys_rst = 1'b1;
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      chk("mid_busy", int'(bus.busy), 0);
      chk("mid_r0", res(0), 0);
      chk("mid_r4", res(4), 0);
      for (int c = 0; c < 30; c++) begin
         if (dones() != 3'b000)
            pulses++;
         @(posedge clk);
         #1;
      end
      chk("mid_no_done", pulses, 0);
      run_op(1, 0, 0, 0, lat, dn, pulses, blow);
      chk("post_lat", lat, 17);
      chk("post_which", int'(dn), 1);
      chk("post_r0", res(0), 512, 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
